// File: rtl/jk_drv_pkg.sv
// Shared types for the JK bank driver: FSM states, 2-bit JK drive codes and
// the single-bit excitation function.
package jk_drv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2
   } state_t;

   // {J,K} codes as applied to one flip-flop
   localparam logic [1:0] HOLD = 2'b00;
   localparam logic [1:0] RST  = 2'b01;
   localparam logic [1:0] SET  = 2'b10;
   localparam logic [1:0] TGL  = 2'b11;

   function automatic logic [1:0] jk_excite(input logic cur, input logic tgt, input logic toggle_en);
      if (cur == tgt) return HOLD;
      if (toggle_en)  return TGL;
      return tgt ? SET : RST;
   endfunction

endpackage

// File: rtl/jk_bank_driver_if.sv
// Command handshake between the target source and the JK bank driver.
interface jk_bank_driver_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_target;
   logic             in_step;

   modport master (output in_valid, in_target, in_step, input in_ready);
   modport slave  (input in_valid, in_target, in_step, output in_ready);
endinterface

// File: rtl/jk_excite_cell.sv
// Combinational J/K excitation for one flip-flop of the bank.
module jk_excite_cell
   import jk_drv_pkg::*;
#(
   parameter bit TOGGLE_EN = 1'b0
) (
   input  logic       cur,
   input  logic       tgt,
   output logic [1:0] jk
);

   assign jk = jk_excite(cur, tgt, TOGGLE_EN);

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flip-flops toward a target word, either all bits at once
// or one bit per cycle LSB-first, then checks the bank and reports mismatches.
module jk_bank_driver
   import jk_drv_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit TOGGLE_EN = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   jk_bank_driver_if.slave  cmd,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             done,
   output logic             err,
   output logic [7:0]       err_cnt
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t                  state, state_nxt;
   logic [WIDTH-1:0]        target_q;
   logic                    step_q;
   logic [IW-1:0]           bit_idx;
   logic                    accept, last_bit, mismatch;
   logic [WIDTH-1:0]        tgt_sel, mask, j_nxt, k_nxt;
   logic [WIDTH-1:0][1:0]   jk;

   assign accept   = cmd.in_valid & cmd.in_ready;
   assign last_bit = (bit_idx == IW'(WIDTH - 1));
   assign mismatch = (q_fb != target_q);
   // The target is still on the bus at the accept edge, latched afterwards
   assign tgt_sel  = (state == IDLE) ? cmd.in_target : target_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_excite_cell #(.TOGGLE_EN(TOGGLE_EN)) u_cell (
         .cur (q_fb[i]),
         .tgt (tgt_sel[i]),
         .jk  (jk[i])
      );
      assign j_nxt[i] = jk[i][1] & mask[i];
      assign k_nxt[i] = jk[i][0] & mask[i];
   end

   // Bits allowed to drive at the coming edge; empty when leaving DRIVE
   always_comb begin
      mask = '0;
      if (state == IDLE) begin
         if (cmd.in_step) mask[0] = 1'b1;
         else             mask    = '1;
      end else if (state == DRIVE && step_q && !last_bit) begin
         mask[bit_idx + 1'b1] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = DRIVE;
         DRIVE:   if (!step_q || last_bit) state_nxt = CHECK;
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign cmd.in_ready = (state == IDLE) & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         j_out    <= '0;
         k_out    <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_cnt  <= '0;
         bit_idx  <= '0;
         target_q <= '0;
         step_q   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: if (accept) begin
               target_q <= cmd.in_target;
               step_q   <= cmd.in_step;
               bit_idx  <= '0;
               j_out    <= j_nxt;
               k_out    <= k_nxt;
            end
            DRIVE: begin
               j_out <= j_nxt;
               k_out <= k_nxt;
               if (step_q && !last_bit) bit_idx <= bit_idx + 1'b1;
            end
            CHECK: begin
               done <= 1'b1;
               err  <= mismatch;
               if (mismatch && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench: two drivers (set/reset and toggle flavours) each feeding a
// behavioural JK bank whose q closes the loop.
module tb_jk_bank_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] j0, k0, j1, k1, qfb0, qfb1;
   logic       done0, err0, done1, err1;
   logic [7:0] ec0, ec1;
   logic [7:0] bq0 = '0, bq1 = '0, stuck = '0;
   int         checks = 0, errors = 0;

   jk_bank_driver_if #(.WIDTH(8)) cmd0 ();
   jk_bank_driver_if #(.WIDTH(8)) cmd1 ();

   jk_bank_driver #(.WIDTH(8), .TOGGLE_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .cmd(cmd0.slave), .q_fb(qfb0),
      .j_out(j0), .k_out(k0), .done(done0), .err(err0), .err_cnt(ec0));

   jk_bank_driver #(.WIDTH(8), .TOGGLE_EN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .cmd(cmd1.slave), .q_fb(qfb1),
      .j_out(j1), .k_out(k1), .done(done1), .err(err1), .err_cnt(ec1));

   always #5 clk = ~clk;

   // JK characteristic equation; stuck bits read back as 0
   always @(posedge clk) begin
      bq0 <= (j0 & ~bq0) | (~k0 & bq0);
      bq1 <= (j1 & ~bq1) | (~k1 & bq1);
   end
   assign qfb0 = bq0 & ~stuck;
   assign qfb1 = bq1;

   task automatic test_reset();
      @(negedge clk); cmd0.in_valid = 1'b1; cmd0.in_target = 8'h00; cmd0.in_step = 1'b1;
      @(negedge clk); cmd0.in_valid = 1'b0;
      @(negedge clk);
      checks++; if (cmd0.in_ready !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", cmd0.in_ready); end
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      checks++; if (j0 !== 8'h00 || k0 !== 8'h00) begin errors++; $display("FAIL rst_jk got %h/%h exp 00/00", j0, k0); end
      checks++; if (done0 !== 1'b0 || ec0 !== 8'h00) begin errors++; $display("FAIL rst_done_cnt got %b/%h exp 0/00", done0, ec0); end
      checks++; if (cmd0.in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_rst got %b exp 0", cmd0.in_ready); end
      rst = 1'b0; #1;
      checks++; if (cmd0.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", cmd0.in_ready); end
      @(negedge clk);
      checks++; if (cmd0.in_ready !== 1'b1 || done0 !== 1'b0) begin errors++; $display("FAIL rst_idle got %b/%b exp 1/0", cmd0.in_ready, done0); end
   endtask

   task automatic test_direct();
      cmd0.in_valid = 1'b1; cmd0.in_target = 8'hA5; cmd0.in_step = 1'b0;
      @(negedge clk); cmd0.in_valid = 1'b0;
      checks++; if (j0 !== 8'hA5 || k0 !== 8'h00) begin errors++; $display("FAIL direct_jk got %h/%h exp a5/00", j0, k0); end
      checks++; if (cmd0.in_ready !== 1'b0) begin errors++; $display("FAIL direct_busy got %b exp 0", cmd0.in_ready); end
      @(negedge clk);
      checks++; if (j0 !== 8'h00 || k0 !== 8'h00 || done0 !== 1'b0) begin errors++; $display("FAIL direct_c1 got %h/%h/%b exp 00/00/0", j0, k0, done0); end
      checks++; if (qfb0 !== 8'hA5) begin errors++; $display("FAIL direct_q got %h exp a5", qfb0); end
      @(negedge clk);
      checks++; if (done0 !== 1'b1 || err0 !== 1'b0) begin errors++; $display("FAIL direct_done got %b/%b exp 1/0", done0, err0); end
      checks++; if (cmd0.in_ready !== 1'b1) begin errors++; $display("FAIL direct_ready got %b exp 1", cmd0.in_ready); end
      @(negedge clk);
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL direct_pulse got %b exp 0", done0); end
   endtask

   task automatic test_hold();
      cmd0.in_valid = 1'b1; cmd0.in_target = 8'hA5; cmd0.in_step = 1'b0;
      @(negedge clk); cmd0.in_valid = 1'b0;
      checks++; if (j0 !== 8'h00 || k0 !== 8'h00) begin errors++; $display("FAIL hold_jk got %h/%h exp 00/00", j0, k0); end
      @(negedge clk); @(negedge clk);
      checks++; if (done0 !== 1'b1 || err0 !== 1'b0) begin errors++; $display("FAIL hold_done got %b/%b exp 1/0", done0, err0); end
   endtask

   task automatic test_step();
      logic [7:0] ek;
      cmd0.in_valid = 1'b1; cmd0.in_target = 8'hFF; cmd0.in_step = 1'b0;
      @(negedge clk); cmd0.in_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      cmd0.in_valid = 1'b1; cmd0.in_target = 8'h0F; cmd0.in_step = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk); cmd0.in_valid = 1'b0;
         ek = (c >= 4) ? 8'(1 << c) : 8'h00;
         checks++; if (j0 !== 8'h00 || k0 !== ek) begin errors++; $display("FAIL step_c%0d got %h/%h exp 00/%h", c, j0, k0, ek); end
      end
      @(negedge clk);
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL step_early got %b exp 0", done0); end
      @(negedge clk);
      checks++; if (done0 !== 1'b1 || err0 !== 1'b0 || qfb0 !== 8'h0F) begin errors++; $display("FAIL step_done got %b/%b/%h exp 1/0/0f", done0, err0, qfb0); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ej, ek;
      cmd0.in_valid = 1'b1; cmd0.in_target = 8'hF0; cmd0.in_step = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c < 8) begin
            ej = (c >= 4) ? 8'(1 << c) : 8'h00;
            ek = (c < 4)  ? 8'(1 << c) : 8'h00;
            checks++; if (j0 !== ej || k0 !== ek) begin errors++; $display("FAIL busy_c%0d got %h/%h exp %h/%h", c, j0, k0, ej, ek); end
         end
         if (c == 2 || c == 5) begin
            checks++; if (cmd0.in_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b exp 0", cmd0.in_ready); end
         end
         cmd0.in_valid = (c == 2 || c == 5); cmd0.in_target = 8'h00; cmd0.in_step = 1'b0;
      end
      @(negedge clk);
      checks++; if (done0 !== 1'b1 || qfb0 !== 8'hF0 || cmd0.in_ready !== 1'b1) begin errors++; $display("FAIL busy_done got %b/%h/%b exp 1/f0/1", done0, qfb0, cmd0.in_ready); end
      cmd0.in_valid = 1'b1; cmd0.in_target = 8'h3C; cmd0.in_step = 1'b0;
      @(negedge clk); cmd0.in_valid = 1'b0;
      checks++; if (j0 !== 8'h0C || k0 !== 8'hC0) begin errors++; $display("FAIL b2b_jk got %h/%h exp 0c/c0", j0, k0); end
      @(negedge clk); @(negedge clk);
      checks++; if (done0 !== 1'b1 || qfb0 !== 8'h3C || err0 !== 1'b0) begin errors++; $display("FAIL b2b_done got %b/%h/%b exp 1/3c/0", done0, qfb0, err0); end
   endtask

   task automatic test_toggle();
      @(negedge clk);
      cmd1.in_valid = 1'b1; cmd1.in_target = 8'hA5; cmd1.in_step = 1'b0;
      @(negedge clk); cmd1.in_valid = 1'b0;
      checks++; if (j1 !== 8'hA5 || k1 !== 8'hA5) begin errors++; $display("FAIL tgl1_jk got %h/%h exp a5/a5", j1, k1); end
      @(negedge clk); @(negedge clk);
      checks++; if (done1 !== 1'b1 || qfb1 !== 8'hA5) begin errors++; $display("FAIL tgl1_done got %b/%h exp 1/a5", done1, qfb1); end
      cmd1.in_valid = 1'b1; cmd1.in_target = 8'h5A;
      @(negedge clk); cmd1.in_valid = 1'b0;
      checks++; if (j1 !== 8'hFF || k1 !== 8'hFF) begin errors++; $display("FAIL tgl2_jk got %h/%h exp ff/ff", j1, k1); end
      @(negedge clk);
      checks++; if (qfb1 !== 8'h5A || j1 !== 8'h00 || done1 !== 1'b0) begin errors++; $display("FAIL tgl2_c1 got %h/%h/%b exp 5a/00/0", qfb1, j1, done1); end
      @(negedge clk);
      checks++; if (done1 !== 1'b1 || err1 !== 1'b0) begin errors++; $display("FAIL tgl2_done got %b/%b exp 1/0", done1, err1); end
   endtask

   task automatic test_error();
      @(negedge clk); stuck = 8'h08;
      cmd0.in_valid = 1'b1; cmd0.in_target = 8'h08; cmd0.in_step = 1'b0;
      @(negedge clk); cmd0.in_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      checks++; if (done0 !== 1'b1 || err0 !== 1'b1 || ec0 !== 8'd1) begin errors++; $display("FAIL err_first got %b/%b/%0d exp 1/1/1", done0, err0, ec0); end
      @(negedge clk);
      checks++; if (done0 !== 1'b0 || err0 !== 1'b1) begin errors++; $display("FAIL err_held got %b/%b exp 0/1", done0, err0); end
      for (int n = 0; n < 254; n++) begin
         cmd0.in_valid = 1'b1;
         @(negedge clk); cmd0.in_valid = 1'b0;
         @(negedge clk); @(negedge clk);
      end
      checks++; if (ec0 !== 8'd255) begin errors++; $display("FAIL err_255 got %0d exp 255", ec0); end
      for (int n = 0; n < 45; n++) begin
         cmd0.in_valid = 1'b1;
         @(negedge clk); cmd0.in_valid = 1'b0;
         @(negedge clk); @(negedge clk);
      end
      checks++; if (ec0 !== 8'd255 || done0 !== 1'b1) begin errors++; $display("FAIL err_sat got %0d/%b exp 255/1", ec0, done0); end
   endtask

   task automatic test_abort();
      bit seen = 1'b0;
      @(negedge clk); stuck = 8'h00;
      cmd0.in_valid = 1'b1; cmd0.in_target = 8'hF7; cmd0.in_step = 1'b1;
      @(negedge clk); cmd0.in_valid = 1'b0;
      checks++; if (j0 !== 8'h01 || k0 !== 8'h00) begin errors++; $display("FAIL abort_c0 got %h/%h exp 01/00", j0, k0); end
      @(negedge clk); @(negedge clk); @(negedge clk);
      checks++; if (j0 !== 8'h00 || k0 !== 8'h08) begin errors++; $display("FAIL abort_c3 got %h/%h exp 00/08", j0, k0); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (j0 !== 8'h00 || k0 !== 8'h00 || done0 !== 1'b0 || ec0 !== 8'h00) begin errors++; $display("FAIL abort_rst got %h/%h/%b/%h exp 00/00/0/00", j0, k0, done0, ec0); end
      checks++; if (qfb0 !== 8'h07) begin errors++; $display("FAIL abort_q got %h exp 07", qfb0); end
      rst = 1'b0; #1;
      checks++; if (cmd0.in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", cmd0.in_ready); end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done0 === 1'b1) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b exp 0", seen); end
   endtask

   initial begin
      cmd0.in_valid = 1'b0; cmd0.in_target = '0; cmd0.in_step = 1'b0;
      cmd1.in_valid = 1'b0; cmd1.in_target = '0; cmd1.in_step = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_direct();
      test_hold();
      test_step();
      test_back_to_back();
      test_toggle();
      test_error();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
